// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sender between N_CLIENTS byte producers.
// Optional sender-handshake watchdog with ABORT state: define ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int N_CLIENTS      = 4,
    parameter int FRAME_CYCLES   = 220,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N_CLIENTS-1:0]   cli_req,
    input  logic [8*N_CLIENTS-1:0] cli_data,
    output logic [N_CLIENTS-1:0]   cli_ack,
    output logic                   snd_req,
    output logic [7:0]             snd_data,
    input  logic                   snd_ack,
    output logic                   busy,
    output logic [2:0]             owner,
    output logic                   err
);

    if (N_CLIENTS < 2 || N_CLIENTS > 8 || FRAME_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: illegal parameter value");
    end

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, GRANT, SREQ, SREL, SEND, ABORT} state_t;
    localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt;
`else
    typedef enum logic [2:0] {IDLE, GRANT, SREQ, SREL, SEND} state_t;
    assign err = 1'b0;
`endif

    localparam logic [15:0] FRAME_LD = 16'(FRAME_CYCLES - 1);

    state_t      state;
    logic [2:0]  ptr;
    logic [15:0] frame_cnt;
    logic        found;
    logic [2:0]  sel;
    logic [N_CLIENTS-1:0] rot;

    function automatic logic [2:0] next_ptr(input logic [2:0] o);
        logic [3:0] s;
        s = {1'b0, o} + 4'd1;
        return (s == 4'(N_CLIENTS)) ? 3'd0 : s[2:0];
    endfunction

    // Rotate requests so bit 0 is the client at ptr; the lowest set bit wins.
    always_comb begin
        logic [3:0] s;
        rot   = N_CLIENTS'({cli_req, cli_req} >> ptr);
        found = 1'b0;
        sel   = 3'd0;
        s     = 4'd0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                s     = {1'b0, ptr} + 4'(k);
                if (s >= 4'(N_CLIENTS)) s = s - 4'(N_CLIENTS);
                sel   = s[2:0];
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cli_ack   <= '0;
            snd_req   <= 1'b0;
            snd_data  <= 8'h00;
            owner     <= 3'd0;
            ptr       <= 3'd0;
            frame_cnt <= 16'd0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt    <= 16'd0;
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    snd_data <= 8'(cli_data >> {sel, 3'b000});
                    owner    <= sel;
                    cli_ack  <= {{(N_CLIENTS-1){1'b0}}, 1'b1} << sel;
                    state    <= GRANT;
                end
                GRANT: if ((cli_req & cli_ack) == '0) begin
                    cli_ack <= '0;
                    snd_req <= 1'b1;
                    state   <= SREQ;
`ifdef ARB_TIMEOUT_EN
                    wd_cnt  <= 16'd0;
`endif
                end
                SREQ: if (snd_ack) begin
                    snd_req <= 1'b0;
                    state   <= SREL;
`ifdef ARB_TIMEOUT_EN
                    wd_cnt  <= 16'd0;
                end else if (wd_cnt >= WD_LIM) begin
                    snd_req <= 1'b0;
                    err     <= 1'b1;
                    state   <= ABORT;
                end else if (wd_cnt != 16'hFFFF) begin
                    wd_cnt  <= wd_cnt + 16'd1;
`endif
                end
                SREL: if (!snd_ack) begin
                    frame_cnt <= FRAME_LD;
                    state     <= SEND;
`ifdef ARB_TIMEOUT_EN
                end else if (wd_cnt >= WD_LIM) begin
                    snd_req <= 1'b0;
                    err     <= 1'b1;
                    state   <= ABORT;
                end else if (wd_cnt != 16'hFFFF) begin
                    wd_cnt  <= wd_cnt + 16'd1;
`endif
                end
                SEND: if (frame_cnt == 16'd0) begin
                    ptr   <= next_ptr(owner);
                    state <= IDLE;
                end else begin
                    frame_cnt <= frame_cnt - 16'd1;
                end
`ifdef ARB_TIMEOUT_EN
                // Byte is dropped; the next client gets the sender.
                ABORT: begin
                    ptr   <= next_ptr(owner);
                    state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
